// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage -- MEM stage of the 5-stage MIPS pipeline.
//
// Holds the EX/MEM pipeline register and runs byte/half/word loads and stores
// over a req/ack data-memory port. While an access is outstanding the stage
// raises stallM so EX and everything upstream hold.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   validE .. memSignedE  EX-stage instruction fields (loaded when stallM=0)
//   stallM             hold EX and upstream
//   validM, aluOutM, writeRegAddrM, regWriteM, memToRegM
//                      registered M-slot fields for forwarding and WB
//   readDataM          aligned, extended load data (latched on ack)
//   addrErrM, busErrM  misaligned access / ack timeout for the op in M
//   dmem_*             data-memory request port
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        validE,
    input  logic [31:0] aluOutE,
    input  logic [31:0] writeDataE,
    input  logic [4:0]  writeRegAddrE,
    input  logic        regWriteE,
    input  logic        memReadE,
    input  logic        memWriteE,
    input  logic [1:0]  memSizeE,
    input  logic        memSignedE,
    output logic        stallM,
    output logic        validM,
    output logic [31:0] aluOutM,
    output logic [4:0]  writeRegAddrM,
    output logic        regWriteM,
    output logic        memToRegM,
    output logic [31:0] readDataM,
    output logic        addrErrM,
    output logic        busErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    // EX/MEM pipeline register
    logic        valid_q;
    logic [31:0] alu_q;
    logic [31:0] wdata_q;
    logic [4:0]  wreg_q;
    logic        regwrite_q;
    logic        memread_q;
    logic        memwrite_q;
    logic [1:0]  size_q;
    logic        signed_q;

    // Access control state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_err_q, bus_err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic        load_en;
    logic        mem_op_e;
    logic        mem_op_m;
    logic        timeout_hit;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic misaligned(input logic [1:0] addr, input logic [1:0] size);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr[0];
            default: return addr != 2'b00;
        endcase
    endfunction

    assign load_en  = (state_q != BUSY);
    assign mem_op_e = validE & (memReadE | memWriteE);
    assign mem_op_m = valid_q & (memread_q | memwrite_q);

    // The op has waited ACK_TIMEOUT req cycles once the counter would reach it
    // at this edge.
    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    // Lane selection and extension of the returned word.
    assign byte_sel = 8'(dmem_rdata >> {alu_q[1:0], 3'b000});
    assign half_sel = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE, DONE: begin
                // A new instruction loads on this edge; only an aligned memory
                // op needs the bus.
                state_d   = (mem_op_e && !misaligned(aluOutE[1:0], memSizeE)) ? BUSY : IDLE;
                cnt_d     = '0;
                bus_err_d = 1'b0;
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_ack) begin
                    state_d = DONE;
                    if (memread_q) rdata_d = load_data;
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            alu_q      <= '0;
            wdata_q    <= '0;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (load_en) begin
                valid_q    <= validE;
                alu_q      <= aluOutE;
                wdata_q    <= writeDataE;
                wreg_q     <= writeRegAddrE;
                regwrite_q <= validE & regWriteE;
                memread_q  <= validE & memReadE;
                memwrite_q <= validE & memWriteE;
                size_q     <= memSizeE;
                signed_q   <= memSignedE;
            end
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Control outputs come from registered state only.
    assign stallM        = (state_q == BUSY);
    assign dmem_req      = (state_q == BUSY);
    assign dmem_we       = (state_q == BUSY) & memwrite_q;
    assign dmem_addr     = {alu_q[31:2], 2'b00};

    assign validM        = valid_q;
    assign aluOutM       = alu_q;
    assign writeRegAddrM = wreg_q;
    assign memToRegM     = memread_q;
    assign readDataM     = rdata_q;
    assign addrErrM      = mem_op_m & misaligned(alu_q[1:0], size_q);
    assign busErrM       = bus_err_q;
    assign regWriteM     = regwrite_q & ~addrErrM & ~bus_err_q;

    always_comb begin
        case (size_q)
            2'b00: begin
                dmem_be    = 4'b0001 << alu_q[1:0];
                dmem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << {alu_q[1], 1'b0};
                dmem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = wdata_q;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage -- directed testbench for mem_stage (ACK_TIMEOUT = 4).
// ----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        validE;
    logic [31:0] aluOutE;
    logic [31:0] writeDataE;
    logic [4:0]  writeRegAddrE;
    logic        regWriteE;
    logic        memReadE;
    logic        memWriteE;
    logic [1:0]  memSizeE;
    logic        memSignedE;
    logic        stallM;
    logic        validM;
    logic [31:0] aluOutM;
    logic [4:0]  writeRegAddrM;
    logic        regWriteM;
    logic        memToRegM;
    logic [31:0] readDataM;
    logic        addrErrM;
    logic        busErrM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;
    int req_cycles;

    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .validE(validE), .aluOutE(aluOutE), .writeDataE(writeDataE),
        .writeRegAddrE(writeRegAddrE), .regWriteE(regWriteE),
        .memReadE(memReadE), .memWriteE(memWriteE),
        .memSizeE(memSizeE), .memSignedE(memSignedE),
        .stallM(stallM), .validM(validM), .aluOutM(aluOutM),
        .writeRegAddrM(writeRegAddrM), .regWriteM(regWriteM),
        .memToRegM(memToRegM), .readDataM(readDataM),
        .addrErrM(addrErrM), .busErrM(busErrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] rd, input logic rw, input logic rd_en,
                           input logic wr_en, input logic [1:0] size, input logic sgn);
        validE = v; aluOutE = alu; writeDataE = wd; writeRegAddrE = rd;
        regWriteE = rw; memReadE = rd_en; memWriteE = wr_en;
        memSizeE = size; memSignedE = sgn;
    endtask

    task automatic bubble();
        drive_e(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    endtask

    // Serve the op in M: ack in req cycle ack_cycle (0 = never), checking the
    // request fields every req cycle. Bounded so a stuck request cannot hang.
    task automatic serve(input string tag, input int ack_cycle, input logic [31:0] rdata,
                         input logic exp_we, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_addr,
                         input logic [31:0] exp_alu);
        req_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (!dmem_req) break;
            req_cycles++;
            check({tag, ".stall"}, 32'(stallM), 32'd1);
            check({tag, ".we"},    32'(dmem_we), 32'(exp_we));
            check({tag, ".be"},    32'(dmem_be), 32'(exp_be));
            check({tag, ".wdata"}, dmem_wdata, exp_wdata);
            check({tag, ".addr"},  dmem_addr, exp_addr);
            check({tag, ".alu"},   aluOutM, exp_alu);
            dmem_ack   = (req_cycles == ack_cycle);
            dmem_rdata = rdata;
            step();
            dmem_ack = 1'b0;
        end
        check({tag, ".done_stall"}, 32'(stallM), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        bubble();
        step();
        step();
        check("rst.validM",   32'(validM), 32'd0);
        check("rst.regWrite", 32'(regWriteM), 32'd0);
        check("rst.stallM",   32'(stallM), 32'd0);
        check("rst.req",      32'(dmem_req), 32'd0);
        check("rst.aluOutM",  aluOutM, 32'h0);
        check("rst.readData", readDataM, 32'h0);
        rst = 1'b0;

        // ADD: plain pass-through
        drive_e(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        step();
        bubble();
        check("add.aluOutM", aluOutM, 32'h0000_1234);
        check("add.rd",      32'(writeRegAddrM), 32'd5);
        check("add.regWr",   32'(regWriteM), 32'd1);
        check("add.validM",  32'(validM), 32'd1);
        check("add.stall",   32'(stallM), 32'd0);
        check("add.req",     32'(dmem_req), 32'd0);
        check("add.m2r",     32'(memToRegM), 32'd0);
        step();
        check("bub.validM",  32'(validM), 32'd0);
        check("bub.regWr",   32'(regWriteM), 32'd0);

        // SW, ack in 3rd req cycle; next instruction waits upstream meanwhile
        drive_e(1'b1, 32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        step();
        drive_e(1'b1, 32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        serve("sw", 3, 32'h0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h100, 32'h100);
        check("sw.req_cycles", 32'(req_cycles), 32'd3);
        step();
        bubble();
        check("sw.next_alu", aluOutM, 32'h55);
        check("sw.next_rd",  32'(writeRegAddrM), 32'd7);
        check("sw.next_req", 32'(dmem_req), 32'd0);

        // LB signed at 0x103
        drive_e(1'b1, 32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        step();
        bubble();
        serve("lb", 1, 32'h80FF_FFFF, 1'b0, 4'b1000, 32'h0, 32'h100, 32'h103);
        check("lb.req_cycles", 32'(req_cycles), 32'd1);
        check("lb.data",  readDataM, 32'hFFFF_FF80);
        check("lb.m2r",   32'(memToRegM), 32'd1);
        check("lb.regWr", 32'(regWriteM), 32'd1);

        // LBU
        drive_e(1'b1, 32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        step();
        bubble();
        serve("lbu", 1, 32'h80FF_FFFF, 1'b0, 4'b1000, 32'h0, 32'h100, 32'h103);
        check("lbu.data", readDataM, 32'h0000_0080);

        // LH signed at 0x102
        drive_e(1'b1, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
        step();
        bubble();
        serve("lh", 1, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'h100, 32'h102);
        check("lh.data", readDataM, 32'hFFFF_8001);

        // LHU
        drive_e(1'b1, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        step();
        bubble();
        serve("lhu", 1, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'h100, 32'h102);
        check("lhu.data", readDataM, 32'h0000_8001);

        // SH at 0x102
        drive_e(1'b1, 32'h102, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        step();
        bubble();
        serve("sh", 1, 32'h0, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h100, 32'h102);

        // SB at 0x101
        drive_e(1'b1, 32'h101, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        step();
        bubble();
        serve("sb", 1, 32'h0, 1'b1, 4'b0010, 32'h7878_7878, 32'h100, 32'h101);

        // Misaligned LW at 0x101
        drive_e(1'b1, 32'h101, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        step();
        bubble();
        check("lwmis.addrErr", 32'(addrErrM), 32'd1);
        check("lwmis.req",     32'(dmem_req), 32'd0);
        check("lwmis.regWr",   32'(regWriteM), 32'd0);
        check("lwmis.stall",   32'(stallM), 32'd0);
        check("lwmis.validM",  32'(validM), 32'd1);
        step();
        check("lwmis.clear",   32'(addrErrM), 32'd0);
        check("lwmis.req2",    32'(dmem_req), 32'd0);

        // LW at 0x200 with no ack: times out after 4 req cycles
        drive_e(1'b1, 32'h200, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        step();
        bubble();
        serve("to", 0, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h200, 32'h200);
        check("to.req_cycles", 32'(req_cycles), 32'd4);
        check("to.busErr",     32'(busErrM), 32'd1);
        check("to.regWr",      32'(regWriteM), 32'd0);
        step();
        check("to.busErr_clr", 32'(busErrM), 32'd0);
        check("to.resume",     32'(stallM), 32'd0);

        // Reset in the 2nd BUSY cycle, then a late ack
        drive_e(1'b1, 32'h300, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        step();
        bubble();
        check("rbusy.req1", 32'(dmem_req), 32'd1);
        step();
        check("rbusy.req2", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rbusy.req",    32'(dmem_req), 32'd0);
        check("rbusy.stall",  32'(stallM), 32'd0);
        check("rbusy.validM", 32'(validM), 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        step();
        dmem_ack = 1'b0;
        check("late.req",      32'(dmem_req), 32'd0);
        check("late.stall",    32'(stallM), 32'd0);
        check("late.validM",   32'(validM), 32'd0);
        check("late.readData", readDataM, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline; sits directly downstream of the EX stage.
- Holds the EX/MEM pipeline register and performs LB/LBU/LH/LHU/LW/SB/SH/SW through a req/ack data-memory port.
- Stalls the upstream pipeline while an access is outstanding.
- Feeds aluOutM back to EX forwarding, and feeds readDataM and control signals to WB.

Parameters:
- ACK_TIMEOUT, 255: maximum cycles dmem_req waits for dmem_ack before the access is abandoned with busErrM; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- validE  in  1  EX slot holds a real instruction.
- aluOutE  in  32  EX ALU result; effective address for memory ops.
- writeDataE  in  32  store data (forwarded rt).
- writeRegAddrE  in  5  destination register.
- regWriteE  in  1  instruction writes the register file.
- memReadE  in  1  load.
- memWriteE  in  1  store.
- memSizeE  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- memSignedE  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- stallM  out  1  hold the EX stage and everything upstream.
- validM  out  1  M slot valid.
- aluOutM  out  32  registered ALU result (forwarding source).
- writeRegAddrM  out  5  registered destination register.
- regWriteM  out  1  registered write enable, gated by errors.
- memToRegM  out  1  WB selects readDataM (registered memReadE).
- readDataM  out  32  aligned and extended load data.
- addrErrM  out  1  misaligned access in M.
- busErrM  out  1  ack timeout occurred for the op in M.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  {aluOutM[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  access complete; sampled on clk while dmem_req=1.
- dmem_rdata  in  32  read word; valid in the cycle dmem_ack=1.

Behaviour:
- Reset: every registered output clears to 0; FSM goes to IDLE; timeout counter clears to 0.
- Reset during an outstanding access drops dmem_req in the next cycle and discards the op.
- EX/MEM register loads all E inputs on each edge where stallM=0. Otherwise it holds.
- validE=0 loads a bubble: validM, regWriteM, memReadM and memWriteM are all 0.
- memOpM = validM & (memReadM | memWriteM).
- Alignment:
  - Half is misaligned when addr[0]=1.
  - Word is misaligned when addr[1:0]!=0.
  - Misaligned op: addrErrM=1, no request, regWriteM forced 0, stallM=0, and the op leaves in 1 cycle.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load data:
  - The byte or half at the addressed lane is selected from dmem_rdata.
  - It is sign- or zero-extended per memSignedM.
  - It is latched into readDataM on the ack edge and held until the next instruction enters M.
- FSM:
  - IDLE: a non-memory op or bubble passes through in 1 cycle with stallM=0. On entry of an aligned memory op, go to BUSY.
  - BUSY: dmem_req=1, stallM=1. dmem_we, dmem_addr, dmem_be and dmem_wdata stay stable. The timeout counter increments each cycle.
    - dmem_ack=1 at an edge → DONE.
    - Counter reaches ACK_TIMEOUT (when nonzero) → DONE with busErrM=1 and regWriteM forced 0.
  - DONE: dmem_req=0, stallM=0. The next edge loads the next instruction and returns to IDLE, or re-enters BUSY if the new op is a memory op.
- dmem_req, dmem_we and stallM are driven from registered state only; there is no combinational path from dmem_ack.
- Minimum memory-op occupancy of M is 2 cycles: ack in the first req cycle, then DONE.
- dmem_ack while dmem_req=0 is ignored.
- addrErrM and busErrM are held while the op sits in M and clear when the next instruction loads.
- aluOutM, writeRegAddrM and memToRegM stay stable throughout a stall.

Test Plan:
- ADD result 0x00001234 to rd=5, validE=1, no memory op → next cycle aluOutM=0x00001234, writeRegAddrM=5, regWriteM=1, stallM=0, dmem_req never asserted.
- SW, addr 0x100, data 0xDEADBEEF, memory acks 3 cycles after req → dmem_req high for 3 cycles with dmem_we=1, be=4'b1111, wdata=0xDEADBEEF; stallM high over the same cycles; next instruction enters on the edge after DONE.
- LB, addr 0x103, signed, rdata 0x80FFFFFF, immediate ack → dmem_addr=0x100, be=4'b1000, readDataM=0xFFFFFF80.
- LBU, same address and data → readDataM=0x00000080.
- LH at 0x102, signed, rdata 0x8001xxxx → readDataM=0xFFFF8001.
- LHU at 0x102, same data → readDataM=0x00008001.
- SH at 0x102, data 0x0000ABCD → be=4'b1100, wdata=0xABCDABCD.
- LW at 0x101 → addrErrM=1, dmem_req stays 0, regWriteM=0, stallM=0.
- ACK_TIMEOUT=4, LW at 0x200, no ack → dmem_req high for exactly 4 cycles, then busErrM=1, regWriteM=0, pipeline resumes.
- rst=1 during the 2nd BUSY cycle → next cycle dmem_req=0, stallM=0, validM=0; a late dmem_ack has no effect.
